// File: rtl/rof_pkg.sv
// Shared definitions for the rank order filter controller.
//   DEF_DATA_BITS / DEF_RANK_BITS : default sample and rank widths
//   rof_state_e                   : controller state encoding
//   rank_step()                   : rank decrement/increment rule for one slot
package rof_pkg;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_RANK_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } rof_state_e;

    // Existing slot drops one rank when the evicted entry ranked below it,
    // and gains one when it is strictly larger than the incoming sample.
    function automatic logic [31:0] rank_step(input logic [31:0] r,
                                              input logic        dec,
                                              input logic        inc);
        return r - {31'b0, dec} + {31'b0, inc};
    endfunction

endpackage

// File: rtl/rank_logic.sv
// Single-slot rank update, time-multiplexed across the window by the controller.
// Ports:
//   i_new   : incoming sample x
//   s_n     : sample stored in the slot being visited
//   r_n     : current rank of that slot
//   r_0     : rank of the entry being evicted
//   new_r   : updated rank for the slot
//   i_is_ge : x >= s_n, contributes to the rank of x
module rank_logic
    import rof_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int RANK_BITS = DEF_RANK_BITS
) (
    input  logic [DATA_BITS-1:0] i_new,
    input  logic [DATA_BITS-1:0] s_n,
    input  logic [RANK_BITS-1:0] r_n,
    input  logic [RANK_BITS-1:0] r_0,
    output logic [RANK_BITS-1:0] new_r,
    output logic                 i_is_ge
);

    logic [31:0] step;

    always_comb begin
        step    = rank_step(32'(r_n), r_n > r_0, s_n > i_new);
        new_r   = step[RANK_BITS-1:0];
        // Ties count toward x, so a new sample ranks above equal old values.
        i_is_ge = (s_n <= i_new);
    end

endmodule

// File: rtl/rof_rank_ctrl.sv
// Rank order filter sequencing controller.
// Keeps a circular window of 2**RANK_BITS samples with unique ranks, replaces
// the oldest on each accepted sample, updates ranks one slot per cycle, then
// returns the element whose rank matches the cfg_rank latched at accept.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : sample handshake, in_data sample, cfg_rank target
//   out_valid/out_ready  : result handshake, out_data selected sample
//   busy                 : high in UPDATE and DONE
// Optional build macro ROF_PRIME_SUPPRESS_EN: suppress results until the
// window has been filled by WINDOW accepted samples.
//
// state  | meaning
// IDLE   | waiting for a sample, in_ready high
// UPDATE | visiting slots j = 0..WINDOW-1, updating ranks
// DONE   | holding result until out_ready
module rof_rank_ctrl
    import rof_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int RANK_BITS = DEF_RANK_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic [RANK_BITS-1:0] cfg_rank,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 busy
);

    localparam int WINDOW = 1 << RANK_BITS;
    localparam logic [RANK_BITS-1:0] J_LAST = RANK_BITS'(WINDOW - 1);
    localparam logic [RANK_BITS-1:0] ONE_R  = RANK_BITS'(1);

    rof_state_e state_q, state_nx;

    logic [WINDOW-1:0][DATA_BITS-1:0] sample_q;
    logic [WINDOW-1:0][RANK_BITS-1:0] rank_q;
    logic [RANK_BITS-1:0] oldest_q;
    logic [RANK_BITS-1:0] j_q;
    logic [RANK_BITS-1:0] r_o_q;
    logic [RANK_BITS-1:0] tgt_q;
    logic [RANK_BITS-1:0] rx_q;
    logic [DATA_BITS-1:0] x_q;
    logic [DATA_BITS-1:0] sel_q;
    logic                 out_valid_q;
    logic [DATA_BITS-1:0] out_data_q;

    logic [RANK_BITS-1:0] new_r;
    logic                 i_is_ge;
    logic                 is_old;
    logic                 hit;
    logic [RANK_BITS-1:0] rx_nx;
    logic [DATA_BITS-1:0] sel_nx;
    logic                 emit;

`ifdef ROF_PRIME_SUPPRESS_EN
    localparam logic [RANK_BITS:0] PRIME_FULL = (RANK_BITS+1)'(WINDOW);
    logic [RANK_BITS:0] prime_q;
    // Counter already includes the sample in flight.
    assign emit = (prime_q == PRIME_FULL);
`else
    assign emit = 1'b1;
`endif

    rank_logic #(
        .DATA_BITS (DATA_BITS),
        .RANK_BITS (RANK_BITS)
    ) u_rank_logic (
        .i_new   (x_q),
        .s_n     (sample_q[j_q]),
        .r_n     (rank_q[j_q]),
        .r_0     (r_o_q),
        .new_r   (new_r),
        .i_is_ge (i_is_ge)
    );

    always_comb begin
        is_old = (j_q == oldest_q);
        rx_nx  = rx_q + (is_old ? '0 : RANK_BITS'(i_is_ge));
        hit    = !is_old && (new_r == tgt_q);
        sel_nx = hit ? sample_q[j_q] : sel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:   if (in_valid) state_nx = ST_UPDATE;
            ST_UPDATE: if (j_q == J_LAST) state_nx = ST_DONE;
            // Suppressed results leave DONE without a handshake.
            ST_DONE:   if (!out_valid_q || out_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WINDOW; i++) begin
                sample_q[i] <= '0;
                rank_q[i]   <= RANK_BITS'(i);
            end
            oldest_q    <= '0;
            j_q         <= '0;
            r_o_q       <= '0;
            tgt_q       <= '0;
            rx_q        <= '0;
            x_q         <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef ROF_PRIME_SUPPRESS_EN
            prime_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q   <= in_data;
                        r_o_q <= rank_q[oldest_q];
                        tgt_q <= cfg_rank;
                        j_q   <= '0;
                        rx_q  <= '0;
`ifdef ROF_PRIME_SUPPRESS_EN
                        if (prime_q != PRIME_FULL) prime_q <= prime_q + 1'b1;
`endif
                    end
                end
                ST_UPDATE: begin
                    if (!is_old) rank_q[j_q] <= new_r;
                    rx_q  <= rx_nx;
                    sel_q <= sel_nx;
                    j_q   <= j_q + ONE_R;
                    if (j_q == J_LAST) begin
                        sample_q[oldest_q] <= x_q;
                        rank_q[oldest_q]   <= rx_nx;
                        oldest_q           <= oldest_q + ONE_R;
                        out_data_q         <= (rx_nx == tgt_q) ? x_q : sel_nx;
                        out_valid_q        <= emit;
                    end
                end
                ST_DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_rof_rank_ctrl.sv
module tb_rof_rank_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] cfg_rank;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    rof_rank_ctrl #(.DATA_BITS(8), .RANK_BITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_rank  (cfg_rank),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every accepted result against the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] r,
                        input logic [7:0] e, input bit exp_out);
        int k;
        for (k = 0; k < 20 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        cfg_rank = r;
        if (exp_out) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_rank = ~r;   // later changes must not affect the result
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (in_ready && !busy) break;
        end
        if (!(in_ready && !busy)) chk("idle_timeout", 0, 1);
    endtask

    task automatic chk_perm(input string name);
        logic [3:0] seen;
        seen = '0;
        for (int i = 0; i < 4; i++) seen[dut.rank_q[i]] = 1'b1;
        chk(name, 32'(seen), 32'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0] stream_d[4] = '{8'd9, 8'd2, 8'd7, 8'd4};
        logic [7:0] stream_e[4] = '{8'd0, 8'd0, 8'd2, 8'd4};
        logic [1:0] exp_rank[4] = '{2'd3, 2'd0, 2'd1, 2'd2};

        in_valid = 1'b0; in_data = '0; cfg_rank = '0; out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        #1;

        // Push 5, target max; check latency and resulting ranks.
        push(8'd5, 2'd3, 8'd5, 1'b1);
        chk("busy_update", 32'(busy), 1);
        chk("in_ready_update", 32'(in_ready), 0);
        for (k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        chk("latency_edges", 32'(k), 4);
        wait_idle();
        for (int i = 0; i < 4; i++) chk("ranks_after_5", 32'(dut.rank_q[i]), 32'(exp_rank[i]));

        push(8'd3, 2'd3, 8'd5, 1'b1);
        wait_idle();

        // Same pre-state, target rank 1.
        do_reset();
        push(8'd5, 2'd3, 8'd5, 1'b1);
        wait_idle();
        push(8'd3, 2'd1, 8'd0, 1'b1);
        wait_idle();
        chk("slot1_rank", 32'(dut.rank_q[1]), 2);

        // Stream with reset zeros treated as data.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            push(stream_d[n], 2'd1, stream_e[n], 1'b1);
            wait_idle();
            chk_perm("rank_perm");
        end

        // Backpressure: window {9,2,7,4}, push 6 evicts 9, min is 2.
        out_ready = 1'b0;
        push(8'd6, 2'd0, 8'd2, 1'b1);
        for (k = 0; k < 10 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        chk("bp_out_valid_seen", 32'(out_valid), 1);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data  = 8'd99;
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_data", 32'(out_data), 2);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_back_idle", 32'(in_ready), 1);
        chk("bp_valid_drop", 32'(out_valid), 0);
        // Window {6,1,7,4} after evicting 2; 99 must not have entered.
        push(8'd1, 2'd3, 8'd7, 1'b1);
        wait_idle();
        chk_perm("rank_perm_bp");

        // Reset during the third update cycle.
        push(8'd200, 2'd2, 8'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_oldest", 32'(dut.oldest_q), 0);
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_rank", 32'(dut.rank_q[i]), 32'(i));
            chk("mid_rst_sample", 32'(dut.sample_q[i]), 0);
        end

        // Tie: equal new sample ranks above existing zeros -> max is the new 0.
        push(8'd0, 2'd0, 8'd0, 1'b1);
        wait_idle();
        chk("tie_new_rank", 32'(dut.rank_q[0]), 3);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rof_rank_ctrl.md
Name: rof_rank_ctrl

Overview:
- Sequencing controller for the rank order filter datapath.
- Holds a circular window of WINDOW samples, each with a unique rank (0 = smallest).
- On each accepted sample it evicts the oldest entry and runs the rank_logic update serially, one slot per cycle.
- It then returns the window element whose rank equals the configured target: min, median, max or any order statistic.

Parameters:
- DATA_BITS, 8, sample width.
- RANK_BITS, 2, rank width. Window size is the localparam WINDOW = 1<<RANK_BITS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a new sample is offered.
- in_ready  out  1  controller can accept a sample.
- in_data  in  DATA_BITS  new sample.
- cfg_rank  in  RANK_BITS  target rank. Sampled on the accept cycle.
- out_valid  out  1  out_data holds a filtered result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_BITS  sample whose rank equals the latched cfg_rank.
- busy  out  1  high in UPDATE and DONE.

Behaviour:
- Reset (synchronous, active-high, takes effect even mid-operation):
  - sample[i]=0 and rank[i]=i for all slots; oldest pointer=0.
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0.
- States: IDLE, UPDATE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch x=in_data, r_o=rank[oldest] and tgt=cfg_rank; clear slot counter j and x-rank accumulator rx.
  - Go to UPDATE.
- UPDATE: exactly WINDOW cycles, j = 0..WINDOW-1.
  - For j != oldest:
    - rank[j] <= rank[j] - (rank[j] > r_o) + (sample[j] > x).
    - rx <= rx + (sample[j] <= x).
    - If the new rank[j] == tgt, latch sel=sample[j].
  - For j == oldest: no update (that slot is being replaced).
  - Comparisons are unsigned. Ties rank the new sample above existing equal values.
  - Ranks remain a permutation of 0..WINDOW-1 after each update. rx cannot overflow (max WINDOW-1).
- UPDATE exit, last cycle:
  - sample[oldest] <= x; rank[oldest] <= final rx.
  - oldest <= oldest+1, wrapping WINDOW-1 to 0.
  - out_data <= (final rx == tgt) ? x : sel; out_valid <= 1.
  - Go to DONE.
- Latency: accept on cycle N gives out_valid on cycle N+WINDOW+1.
- DONE:
  - out_valid held and out_data stable until out_ready.
  - On the cycle out_valid&&out_ready, go to IDLE.
  - in_ready=0 during UPDATE and DONE, so no new sample is accepted in the handoff cycle. Throughput is one sample per WINDOW+2 cycles.
- cfg_rank changes outside the accept cycle are ignored. Every RANK_BITS value is a legal rank, so no clamping is needed.
- in_valid while in_ready=0: ignored; the sample must be held by the source.

Optional Feature:
- ROF_PRIME_SUPPRESS_EN defined:
  - A saturating counter of accepted samples since reset (0..WINDOW) is added.
  - For the first WINDOW-1 accepted samples, DONE returns directly to IDLE without asserting out_valid. Window state still updates.
  - Output begins with the WINDOW-th sample, when the window holds no reset zeros.
- Not defined: every accepted sample produces a result, with reset zeros treated as real data.

Decomposition:
- Shared package rof_pkg:
  - default DATA_BITS/RANK_BITS;
  - state encoding constants ST_IDLE/ST_UPDATE/ST_DONE;
  - rank-update helper function (decrement/increment rule).
- One sub-module is natural: the existing rank_logic, instantiated once and time-multiplexed across slots.
  - Inputs: i_new=x, s_n=sample[j], r_n=rank[j], r_0=r_o.
  - Outputs used: new_r and i_is_ge for the rx accumulation.
- Controller keeps the storage arrays, pointer, counter and FSM.

Test Plan (DATA_BITS=8, RANK_BITS=2):
- Reset, push in_data=5 with cfg_rank=3 -> out_valid exactly 5 cycles after accept, out_data=5; ranks {slot0..3}={3,0,1,2}.
- Continue: push 3 with cfg_rank=3 -> out_data=5; repeat with cfg_rank=1 on push 3 from the same pre-state -> out_data=0; slot1 rank=2.
- Stream 9,2,7,4 after reset with cfg_rank=1 (feature off) -> final output 4; verify ranks form a permutation after every update.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; release -> back to IDLE next cycle.
- Assert rst during UPDATE cycle 2 -> next cycle IDLE, out_valid=0, ranks {0,1,2,3}, samples 0, oldest=0.
- ROF_PRIME_SUPPRESS_EN defined: push 4 samples -> out_valid only after the 4th; the 5th onwards always produce output.
